// File: rtl/dso_cap_pkg.sv
// dso_capture shared types, widths and the decimation mask helper.
// DEPTH_LOG2_DEF is the default capture RAM address width.
package dso_cap_pkg;

    localparam int DEPTH_LOG2_DEF = 9;
    localparam int SAMPLE_W       = 24;
    localparam int CH_W           = 8;
    localparam int DEC_W          = 4;
    localparam int DCNT_W         = 15;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST,
        DONE
    } cap_state_t;

    function automatic logic [DCNT_W-1:0] dec_mask(
        input logic [DEC_W-1:0] dec
    );
        logic [DCNT_W:0] one_hot;
        one_hot = (DCNT_W+1)'(1) << dec;
        return DCNT_W'(one_hot - 1'b1);
    endfunction

endpackage

// File: rtl/dso_capture_if.sv
// Capture RAM write port plus readout status of dso_capture.
// master = capture engine, slave = RAM / readout side.
interface dso_capture_if
    import dso_cap_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) ();

    logic                  we;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [SAMPLE_W-1:0]   wdata;
    logic [DEPTH_LOG2-1:0] trig_addr;
    logic                  cap_done;
    logic                  armed;
    logic                  auto_trig;

    modport master (
        output we,
        output waddr,
        output wdata,
        output trig_addr,
        output cap_done,
        output armed,
        output auto_trig
    );

    modport slave (
        input we,
        input waddr,
        input wdata,
        input trig_addr,
        input cap_done,
        input armed,
        input auto_trig
    );

endinterface

// File: rtl/dso_trig_detect.sv
// Trigger source select and edge compare, evaluated only on sample
// enables so the comparison runs at the decimated sample rate.
module dso_trig_detect (
    input  logic adc_clk,
    input  logic rst_n,
    input  logic se,
    input  logic trig1,
    input  logic trig2,
    input  logic trig_src,
    input  logic trig_edge,
    output logic trig_hit
);

    logic t;
    logic trig_prev;

    assign t = trig_src ? trig2 : trig1;

    // not cleared by arm: an edge spanning arm stays visible
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_prev <= 1'b0;
        end else if (se) begin
            trig_prev <= t;
        end
    end

    assign trig_hit = se & (trig_edge ? (~trig_prev & t)
                                      : (trig_prev & ~t));

endmodule

// File: rtl/dso_capture.sv
// dso_capture: decimating circular capture with pre/post trigger hold.
// Define AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT samples.
module dso_capture
    import dso_cap_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic                  adc_clk,
    input  logic                  rst_n,
    input  logic [CH_W-1:0]       ch1_data,
    input  logic [CH_W-1:0]       ch2_data,
    input  logic [CH_W-1:0]       ch3_data,
    input  logic                  trig1,
    input  logic                  trig2,
    input  logic                  arm,
    input  logic                  trig_src,
    input  logic                  trig_edge,
    input  logic [DEPTH_LOG2-1:0] trig_pos,
    input  logic [DEC_W-1:0]      decimator,
    dso_capture_if.master         cap
);

    localparam int N = DEPTH_LOG2;

    cap_state_t          state;
    logic                src_q;
    logic                edge_q;
    logic [DEC_W-1:0]    dec_q;
    logic [N-1:0]        tp_q;
    logic [N-1:0]        wptr;
    logic [N-1:0]        smpl_cnt;
    logic [N-1:0]        post_cnt;
    logic [DCNT_W-1:0]   dec_cnt;
    logic                run;
    logic                se;
    logic                trig_hit;
    logic                force_hit;
    logic                hit;
    logic                we_q;
    logic [N-1:0]        waddr_q;
    logic [SAMPLE_W-1:0] wdata_q;
    logic [N-1:0]        trig_addr_q;
    logic                cap_done_q;
    logic                armed_q;

    assign run = (state == PRE_FILL)
               | (state == WAIT_TRIG)
               | (state == POST);

    // phase 0 samples, so the first armed cycle is always a sample
    assign se  = run & (dec_cnt == '0);
    assign hit = trig_hit | force_hit;

    dso_trig_detect u_trig (
        .adc_clk   (adc_clk),
        .rst_n     (rst_n),
        .se        (se),
        .trig1     (trig1),
        .trig2     (trig2),
        .trig_src  (src_q),
        .trig_edge (edge_q),
        .trig_hit  (trig_hit)
    );

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            src_q       <= 1'b0;
            edge_q      <= 1'b0;
            dec_q       <= '0;
            tp_q        <= '0;
            wptr        <= '0;
            smpl_cnt    <= '0;
            post_cnt    <= '0;
            dec_cnt     <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            trig_addr_q <= '0;
            cap_done_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (arm) begin
                src_q      <= trig_src;
                edge_q     <= trig_edge;
                dec_q      <= decimator;
                tp_q       <= (trig_pos == '0) ? N'(1) : trig_pos;
                wptr       <= '0;
                smpl_cnt   <= '0;
                dec_cnt    <= '0;
                cap_done_q <= 1'b0;
                armed_q    <= 1'b1;
                state      <= PRE_FILL;
            end else begin
                if (run) begin
                    dec_cnt <= (dec_cnt == dec_mask(dec_q))
                             ? '0 : dec_cnt + 1'b1;
                end
                if (se) begin
                    we_q    <= 1'b1;
                    waddr_q <= wptr;
                    wdata_q <= {ch3_data, ch2_data, ch1_data};
                    wptr    <= wptr + 1'b1;
                end
                unique case (state)
                    PRE_FILL: begin
                        // ~tp_q == DEPTH - trig_pos - 1 (last pre sample)
                        if (se) begin
                            smpl_cnt <= smpl_cnt + 1'b1;
                            if (smpl_cnt == ~tp_q) begin
                                state <= WAIT_TRIG;
                            end
                        end
                    end
                    WAIT_TRIG: begin
                        if (hit) begin
                            trig_addr_q <= wptr;
                            post_cnt    <= tp_q - 1'b1;
                            if (tp_q == N'(1)) begin
                                state   <= DONE;
                                armed_q <= 1'b0;
                            end else begin
                                state <= POST;
                            end
                        end
                    end
                    POST: begin
                        if (se) begin
                            post_cnt <= post_cnt - 1'b1;
                            if (post_cnt == N'(1)) begin
                                state   <= DONE;
                                armed_q <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        cap_done_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            auto_q;

    assign force_hit = se & (state == WAIT_TRIG)
                     & (to_cnt == TO_W'(AUTO_TIMEOUT - 1));

    // WAIT_TRIG is only entered after an arm, which clears the count
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            auto_q <= 1'b0;
        end else if (arm) begin
            to_cnt <= '0;
            auto_q <= 1'b0;
        end else if (se && state == WAIT_TRIG) begin
            to_cnt <= to_cnt + 1'b1;
            if (force_hit && !trig_hit) begin
                auto_q <= 1'b1;
            end
        end
    end

    assign cap.auto_trig = auto_q;
`else
    // AUTO_TIMEOUT has no effect without the forced trigger
    if (AUTO_TIMEOUT < 1) begin : g_no_timeout
    end

    assign force_hit     = 1'b0;
    assign cap.auto_trig = 1'b0;
`endif

    assign cap.we        = we_q;
    assign cap.waddr     = waddr_q;
    assign cap.wdata     = wdata_q;
    assign cap.trig_addr = trig_addr_q;
    assign cap.cap_done  = cap_done_q;
    assign cap.armed     = armed_q;

endmodule

// File: tb/tb_dso_capture.sv
// Randomized bench for dso_capture against a sample-level capture model.
// Honors AUTO_TRIG_EN with AUTO_TIMEOUT overridden to 16.
module tb_dso_capture;
    import dso_cap_pkg::*;

    localparam int DEPTH = 512;
    localparam int MAXS  = 2048;
    localparam int SCAN  = 600;
    localparam int TMO   = 16;

    logic       adc_clk = 1'b0;
    logic       rst_n;
    logic [7:0] ch1_data, ch2_data, ch3_data;
    logic       trig1, trig2, arm, trig_src, trig_edge;
    logic [8:0] trig_pos;
    logic [3:0] decimator;

    dso_capture_if #(.DEPTH_LOG2(9)) cap ();

    dso_capture #(
        .DEPTH_LOG2   (9),
        .AUTO_TIMEOUT (TMO)
    ) dut (
        .adc_clk   (adc_clk),
        .rst_n     (rst_n),
        .ch1_data  (ch1_data),
        .ch2_data  (ch2_data),
        .ch3_data  (ch3_data),
        .trig1     (trig1),
        .trig2     (trig2),
        .arm       (arm),
        .trig_src  (trig_src),
        .trig_edge (trig_edge),
        .trig_pos  (trig_pos),
        .decimator (decimator),
        .cap       (cap)
    );

    always #5 adc_clk = ~adc_clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_taddr = 0;
    int          last_waddr = 0;
    bit          plan [MAXS];
    logic [23:0] exp_data [MAXS];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_rand();
        ch1_data = 8'($urandom);
        ch2_data = 8'($urandom);
        ch3_data = 8'($urandom);
        trig1    = 1'($urandom);
        trig2    = 1'($urandom);
    endtask

    // selected trigger level per sample, toggling at e1, e2, e3
    task automatic plan_steps(input bit lvl0, input int e1,
                              input int e2, input int e3);
        for (int n = 0; n < MAXS; n++)
            plan[n] = lvl0 ^ (n >= e1) ^ (n >= e2) ^ (n >= e3);
    endtask

    task automatic plan_rand();
        bit lvl;
        lvl = 1'($urandom);
        for (int n = 0; n < MAXS; n++) begin
            if ($urandom_range(0, 63) == 0) lvl = !lvl;
            plan[n] = lvl;
        end
    endtask

    // first sample index at/after pre that triggers, -1 if none
    function automatic int find_trig(input int pre, input bit rise,
                                     output bit forced);
        forced = 1'b0;
        for (int k = pre; k < pre + SCAN; k++) begin
            if (rise ? (!plan[k-1] && plan[k])
                     : (plan[k-1] && !plan[k]))
                return k;
`ifdef AUTO_TRIG_EN
            if (k - pre + 1 == TMO) begin
                forced = 1'b1;
                return k;
            end
`endif
        end
        return -1;
    endfunction

    task automatic run_cap(input int tp_in, input int dec,
                           input bit src, input bit rise,
                           input int abort_at);
        int tp, pre, per, k, total, budget, nw, last_we, n;
        bit forced, done;
        tp      = (tp_in == 0) ? 1 : tp_in;
        pre     = DEPTH - tp;
        per     = 1 << dec;
        k       = find_trig(pre, rise, forced);
        total   = (k < 0) ? -1 : k + tp;
        budget  = (k < 0) ? (pre + SCAN) * per
                          : (total + 2) * per + 4;
        nw      = 0;
        last_we = -1;
        done    = 1'b0;

        drive_rand();
        arm       = 1'b1;
        trig_src  = src;
        trig_edge = rise;
        trig_pos  = 9'(tp_in);
        decimator = 4'(dec);
        @(posedge adc_clk); #1;
        arm = 1'b0;
        chk("arm_we", cap.we, 0);
        chk("arm_done", cap.cap_done, 0);
        chk("arm_armed", cap.armed, 1);
        chk("arm_auto", cap.auto_trig, 0);
        chk("arm_taddr", cap.trig_addr, exp_taddr);

        for (int c = 0; c < budget && !done; c++) begin
            if (abort_at >= 0 && nw == abort_at) begin
                chk("abort_armed", cap.armed, 1);
                chk("abort_taddr", cap.trig_addr, k % DEPTH);
                exp_taddr = k % DEPTH;
                return;
            end
            drive_rand();
            if (c % per == 0) begin
                n = c / per;
                if (src) trig2 = plan[n];
                else     trig1 = plan[n];
                exp_data[n] = {ch3_data, ch2_data, ch1_data};
            end
            @(posedge adc_clk); #1;
            if (cap.we) begin
                if (nw > 0) chk("we_gap", c - last_we, per);
                if (nw < MAXS) begin
                    chk("waddr", cap.waddr, nw % DEPTH);
                    chk("wdata", cap.wdata, exp_data[nw]);
                end
                last_waddr = int'(cap.waddr);
                last_we    = c;
                nw++;
            end
            if (cap.cap_done) begin
                done = 1'b1;
                chk("done_lat", c - last_we, 1);
            end
        end

        if (k >= 0) begin
            chk("done_seen", done, 1);
            chk("n_writes", nw, total);
            chk("trig_addr", cap.trig_addr, k % DEPTH);
            chk("auto_trig", cap.auto_trig, forced);
            chk("done_armed", cap.armed, 0);
            exp_taddr = k % DEPTH;
            repeat (8) begin
                drive_rand();
                @(posedge adc_clk); #1;
                if (cap.we) nw++;
            end
            chk("hold_writes", nw, total);
            chk("hold_done", cap.cap_done, 1);
        end else begin
            chk("no_done", done, 0);
            chk("still_armed", cap.armed, 1);
            chk("no_auto", cap.auto_trig, 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        arm       = 1'b0;
        trig_src  = 1'b0;
        trig_edge = 1'b0;
        trig_pos  = '0;
        decimator = '0;
        ch1_data  = '0;
        ch2_data  = '0;
        ch3_data  = '0;
        trig1     = 1'b0;
        trig2     = 1'b0;
        repeat (3) @(posedge adc_clk);
        #1;
        chk("rst_we", cap.we, 0);
        chk("rst_waddr", cap.waddr, 0);
        chk("rst_wdata", cap.wdata, 0);
        chk("rst_taddr", cap.trig_addr, 0);
        chk("rst_done", cap.cap_done, 0);
        chk("rst_armed", cap.armed, 0);
        chk("rst_auto", cap.auto_trig, 0);
        @(negedge adc_clk);
        rst_n = 1'b1;
        @(posedge adc_clk); #1;
        chk("idle_we", cap.we, 0);

        // rising trig1 at sample 300, 256 post samples
        plan_steps(1'b0, 300, MAXS, MAXS);
        run_cap(256, 0, 1'b0, 1'b1, -1);
        chk("t1_taddr", cap.trig_addr, 300);
        chk("t1_last", last_waddr, 43);

        // early edge held high, then fall and rise again
        plan_steps(1'b0, 100, 350, 400);
        run_cap(256, 0, 1'b0, 1'b1, -1);
        chk("t2_taddr", cap.trig_addr, 400);

        // decimate by 4
        plan_steps(1'b0, 400, MAXS, MAXS);
        run_cap(200, 2, 1'b0, 1'b1, -1);

        // trig2 falling at 511, single post sample
        plan_steps(1'b1, 511, MAXS, MAXS);
        run_cap(1, 0, 1'b1, 1'b0, -1);
        chk("t4_taddr", cap.trig_addr, 511);
        chk("t4_last", last_waddr, 511);

        // trig_pos 0 behaves as 1
        plan_steps(1'b1, 520, MAXS, MAXS);
        run_cap(0, 0, 1'b0, 1'b0, -1);

        // re-arm in the middle of POST
        plan_steps(1'b0, 250, MAXS, MAXS);
        run_cap(300, 0, 1'b0, 1'b1, 260);
        plan_steps(1'b0, 450, MAXS, MAXS);
        run_cap(100, 1, 1'b1, 1'b1, -1);

        // no edges: forced trigger only with the timeout built in
        plan_steps(1'b0, MAXS, MAXS, MAXS);
        run_cap(500, 0, 1'b0, 1'b1, -1);

        for (int i = 0; i < 4; i++) begin
            plan_rand();
            run_cap(int'($urandom_range(0, 511)),
                    int'($urandom_range(0, 2)),
                    1'($urandom), 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
